// File: rtl/axi4_lite_master_bridge.sv
// AXI4-Lite master bridge: turns single-beat host requests into AXI4-Lite transactions, one outstanding at a time.
// Optional watchdog: define AXI4_LITE_MASTER_TIMEOUT_EN to force an error completion after TIMEOUT_CYCLES.
module axi4_lite_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic                    iREQ,
  input  logic                    iWE,
  input  logic [ADDR_WIDTH-1:0]   iADDR,
  input  logic [DATA_WIDTH-1:0]   iWDATA,
  input  logic [DATA_WIDTH/8-1:0] iWSTRB,
  output logic                    oBUSY,
  output logic                    oDONE,
  output logic [DATA_WIDTH-1:0]   oRDATA,
  output logic                    oERR,
  output logic                    m_AWVALID,
  input  logic                    m_AWREADY,
  output logic [ADDR_WIDTH-1:0]   m_AWADDR,
  output logic [2:0]              m_AWPROT,
  output logic                    m_WVALID,
  input  logic                    m_WREADY,
  output logic [DATA_WIDTH-1:0]   m_WDATA,
  output logic [DATA_WIDTH/8-1:0] m_WSTRB,
  input  logic                    m_BVALID,
  output logic                    m_BREADY,
  input  logic [1:0]              m_BRESP,
  output logic                    m_ARVALID,
  input  logic                    m_ARREADY,
  output logic [ADDR_WIDTH-1:0]   m_ARADDR,
  output logic [2:0]              m_ARPROT,
  input  logic                    m_RVALID,
  output logic                    m_RREADY,
  input  logic [DATA_WIDTH-1:0]   m_RDATA,
  input  logic [1:0]              m_RRESP
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

  state_t                  state, state_nxt;
  logic                    aw_done, w_done;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs, timeout;

  assign aw_hs = m_AWVALID & m_AWREADY;
  assign w_hs  = m_WVALID & m_WREADY;
  assign b_hs  = m_BVALID & m_BREADY;
  assign ar_hs = m_ARVALID & m_ARREADY;
  assign r_hs  = m_RVALID & m_RREADY;

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST)                                tmo_cnt <= '0;
    else if (state == IDLE)                   tmo_cnt <= '0;
    else if (tmo_cnt < CNT_W'(TIMEOUT_CYCLES)) tmo_cnt <= tmo_cnt + 1'b1;
  end

  // The cycle holding count TIMEOUT_CYCLES-1 is the last permitted non-IDLE cycle.
  assign timeout = (state != IDLE) && (state != DONE) &&
                   (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (iREQ) state_nxt = iWE ? WR_REQ : RD_REQ;
      WR_REQ:  if ((aw_done | aw_hs) && (w_done | w_hs)) state_nxt = WR_RESP;
      WR_RESP: if (b_hs) state_nxt = DONE;
      RD_REQ:  if (ar_hs) state_nxt = RD_RESP;
      RD_RESP: if (r_hs) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (timeout) state_nxt = DONE;
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      oRDATA  <= '0;
      oERR    <= 1'b0;
    end else begin
      if (state == IDLE) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (iREQ) begin
          addr_q  <= iADDR;
          wdata_q <= iWDATA;
          wstrb_q <= iWSTRB;
        end
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (timeout)   oERR <= 1'b1;
      else if (b_hs) oERR <= m_BRESP[1];
      else if (r_hs) begin
        oERR   <= m_RRESP[1];
        oRDATA <= m_RDATA;
      end
    end
  end

  // Every output decodes registered state only, so no input reaches an output combinationally.
  always_comb begin
    oBUSY     = (state != IDLE);
    oDONE     = (state == DONE);
    m_AWVALID = (state == WR_REQ) && !aw_done;
    m_WVALID  = (state == WR_REQ) && !w_done;
    m_BREADY  = (state == WR_RESP);
    m_ARVALID = (state == RD_REQ);
    m_RREADY  = (state == RD_RESP);
    m_AWADDR  = addr_q;
    m_ARADDR  = addr_q;
    m_WDATA   = wdata_q;
    m_WSTRB   = wstrb_q;
    m_AWPROT  = 3'b000;
    m_ARPROT  = 3'b000;
  end
endmodule

// File: doc/axi4_lite_master_bridge.md
Name: axi4_lite_master_bridge

Overview:
AXI4-Lite initiator (master) that converts the core's simple single-beat memory request interface into AXI4-Lite write and read transactions. It drives the AXI4-Lite slave wrappers (RAM, peripherals) over the SoC interconnect. One outstanding transaction at a time. Completion is signalled to the host with a one-cycle done pulse.

Parameters:
ADDR_WIDTH, 32, AXI/host address width
DATA_WIDTH, 32, AXI/host data width (multiple of 8)
TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with AXI4_LITE_MASTER_TIMEOUT_EN

Ports:
iCLK  in  1  clock
iRST  in  1  reset, asynchronous, active-low
iREQ  in  1  host request strobe, sampled in IDLE only
iWE  in  1  1 = write, 0 = read
iADDR  in  ADDR_WIDTH  host address
iWDATA  in  DATA_WIDTH  host write data
iWSTRB  in  DATA_WIDTH/8  host byte strobes
oBUSY  out  1  high whenever state != IDLE
oDONE  out  1  one-cycle completion pulse
oRDATA  out  DATA_WIDTH  last read data
oERR  out  1  last completion had error response
m_AWVALID/m_AWREADY/m_AWADDR/m_AWPROT  out/in/out/out  1/1/ADDR_WIDTH/3  write address channel
m_WVALID/m_WREADY/m_WDATA/m_WSTRB  out/in/out/out  1/1/DATA_WIDTH/DATA_WIDTH/8  write data channel
m_BVALID/m_BREADY/m_BRESP  in/out/in  1/1/2  write response channel
m_ARVALID/m_ARREADY/m_ARADDR/m_ARPROT  out/in/out/out  1/1/ADDR_WIDTH/3  read address channel
m_RVALID/m_RREADY/m_RDATA/m_RRESP  in/out/in/in  1/1/DATA_WIDTH/2  read data channel

Behaviour:
- Reset (async, iRST=0): state IDLE. All VALID/READY outputs 0, oDONE 0, oBUSY 0, oERR 0, oRDATA 0, latched address/data/strobe 0. A reset asserted mid-transaction abandons it; VALIDs drop immediately. No completion pulse is generated.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE: on posedge with iREQ=1, latch iADDR, iWDATA and iWSTRB, then go to WR_REQ (iWE=1) or RD_REQ (iWE=0). iREQ outside IDLE is ignored; no queueing.
- m_AWPROT and m_ARPROT are fixed at 3'b000.
- WR_REQ: AWVALID and WVALID are both asserted on entry and tracked by independent done flags. Each VALID drops the cycle after its own handshake (VALID&READY at a posedge). The two handshakes may occur in the same cycle or in either order. When both are done, go to WR_RESP.
- WR_RESP: BREADY=1. On BVALID&BREADY, capture BRESP and go to DONE. BREADY=0 outside WR_RESP.
- RD_REQ: ARVALID=1 until ARREADY handshake, then go to RD_RESP.
- RD_RESP: RREADY=1. On RVALID&RREADY, capture RDATA into oRDATA and capture RRESP, then go to DONE.
- DONE: oDONE=1 for exactly this cycle. oERR = captured resp[1] (SLVERR/DECERR=1; OKAY/EXOKAY=0). Next state is IDLE, so a new iREQ is accepted at the earliest one cycle after oDONE.
- AXI rules:
  - VALID is never gated by READY.
  - Payload (addr/data/strb) is stable while VALID is high.
  - No combinational path from any input to any output.
- Latency with an always-ready, zero-wait slave:
  - write: iREQ edge t0, AW/W handshake t1, B handshake t2, oDONE t3.
  - read: AR handshake t1, R handshake t2, oDONE t3.
- oRDATA holds until the next read completes; writes never change it. oERR holds until the next DONE.

Optional Feature:
AXI4_LITE_MASTER_TIMEOUT_EN
- Defined: a counter clears in IDLE and increments in every other state.
- When it reaches TIMEOUT_CYCLES, the FSM forces DONE with oERR=1. All VALID/READY outputs deassert the next cycle. oRDATA is unchanged.
- Not defined: no counter exists and the bridge waits indefinitely for handshakes.

Test Plan:
- Write 0x1000 = 0xCAFEBABE, WSTRB 4'hF, slave always ready, BRESP OKAY -> AW/W handshake t1, BREADY t2, oDONE t3, oERR=0; read back gives oRDATA=0xCAFEBABE.
- Write with AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after t1, AWVALID held with stable AWADDR until its handshake, then single oDONE.
- Read 0x2000 with RRESP=SLVERR, RDATA=0x12345678 -> oERR=1, oRDATA=0x12345678, oDONE one cycle.
- iREQ held high continuously during a read -> exactly one transaction per IDLE visit; back-to-back requests are accepted every 4 cycles with a zero-wait slave.
- iRST pulled low while ARVALID=1 -> ARVALID, oBUSY and oRDATA go to 0 immediately, no oDONE; after release, a new read completes normally.
- (TIMEOUT_EN, TIMEOUT_CYCLES=8) BVALID never asserted -> oDONE with oERR=1 after 8 non-IDLE cycles, then BREADY=0 and state IDLE.
